mm_sequencer: RTL and testbench

Control sequencer for the 8x8 matrix-multiply datapath. On `start` it walks every output element C[i][j] in row-major order. For each element it issues the K operand reads from the A and B buffers, steers the MAC's clear/enable strobes, and presents the finished 32-bit result slot to the result writer through a valid/ready handshake. It sits between the top-level command interface and the operand memories, MAC, and result buffer. It carries no data itself, only addresses and strobes.

---
 rtl/mm_sequencer_pkg.sv | 32 +++
 rtl/mm_sequencer_wrap.sv | 42 ++++
 rtl/mm_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_mm_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | mm_sequencer_pkg : shared sizes, address widths and sequencer states  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package mm_sequencer_pkg;

    localparam int MM_N_ROWS_A = 8;
    localparam int MM_N_COLS_A = 8;
    localparam int MM_N_COLS_B = 8;

    // Never narrower than one bit, so single-entry dimensions still get a port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MM_A_AW = addr_w(MM_N_ROWS_A * MM_N_COLS_A);
    localparam int MM_B_AW = addr_w(MM_N_COLS_A * MM_N_COLS_B);
    localparam int MM_C_AW = addr_w(MM_N_ROWS_A * MM_N_COLS_B);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } mm_state_t;

endpackage

`default_nettype wire

// File: rtl/mm_sequencer_wrap.sv
// +----------------------------------------------------------------------+
// | mm_wrap_counter : modulo-MAX counter flagging its final value         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mm_wrap_counter
    import mm_sequencer_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    output logic o_at_max
);

    localparam int W = addr_w(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign o_at_max = (count_q == W'(MAX - 1));

    always_comb begin
        count_d = count_q;
        if (i_inc) begin
            count_d = o_at_max ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mm_sequencer.sv
// +----------------------------------------------------------------------+
// | mm_sequencer : walks C[i][j] row-major, issuing operand reads, MAC    |
// | strobes and result handshakes.  Revision: 1.0                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mm_sequencer
    import mm_sequencer_pkg::*;
#(
    parameter int N_ROWS_A = MM_N_ROWS_A,
    parameter int N_COLS_A = MM_N_COLS_A,
    parameter int N_COLS_B = MM_N_COLS_B
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      a_rd_en,
    output logic [addr_w(N_ROWS_A*N_COLS_A)-1:0]      a_rd_addr,
    output logic                                      b_rd_en,
    output logic [addr_w(N_COLS_A*N_COLS_B)-1:0]      b_rd_addr,
    output logic                                      mac_en,
    output logic                                      mac_clear,
    output logic                                      res_valid,
    output logic [addr_w(N_ROWS_A*N_COLS_B)-1:0]      res_addr,
    input  logic                                      res_ready
);

    localparam int A_AW = addr_w(N_ROWS_A * N_COLS_A);
    localparam int B_AW = addr_w(N_COLS_A * N_COLS_B);
    localparam int C_AW = addr_w(N_ROWS_A * N_COLS_B);

    mm_state_t       state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_en_q, rd_en_d;
    logic            mac_en_q, mac_en_d;
    logic            mac_clear_q, mac_clear_d;
    logic            res_valid_q, res_valid_d;
    logic [A_AW-1:0] a_addr_q, a_addr_d;
    logic [A_AW-1:0] row_base_q, row_base_d;
    logic [B_AW-1:0] b_addr_q, b_addr_d;
    logic [B_AW-1:0] b_base_q, b_base_d;
    logic [C_AW-1:0] res_addr_q, res_addr_d;

    logic k_inc, k_last;
    logic hs, j_last, i_inc, i_last;

    assign k_inc = (state_q == READ);
    assign hs    = (state_q == WRITE) && res_ready;
    assign i_inc = hs && j_last;

    mm_wrap_counter #(.MAX(N_COLS_A)) u_k_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (k_inc),
        .o_at_max (k_last)
    );

    mm_wrap_counter #(.MAX(N_COLS_B)) u_j_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (hs),
        .o_at_max (j_last)
    );

    mm_wrap_counter #(.MAX(N_ROWS_A)) u_i_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (i_inc),
        .o_at_max (i_last)
    );

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        rd_en_d     = rd_en_q;
        res_valid_d = res_valid_q;
        a_addr_d    = a_addr_q;
        row_base_d  = row_base_q;
        b_addr_d    = b_addr_q;
        b_base_d    = b_base_q;
        res_addr_d  = res_addr_q;
        mac_en_d    = rd_en_q;
        // The k=0 read is the only one whose A address equals the row base.
        mac_clear_d = rd_en_q && (a_addr_q == row_base_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                end
            end
            READ: begin
                if (k_last) begin
                    state_d  = DRAIN;
                    rd_en_d  = 1'b0;
                    a_addr_d = row_base_q;
                    b_addr_d = b_base_q;
                end else begin
                    a_addr_d = a_addr_q + A_AW'(1);
                    b_addr_d = b_addr_q + B_AW'(N_COLS_B);
                end
            end
            DRAIN: begin
                state_d     = WRITE;
                res_valid_d = 1'b1;
            end
            WRITE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (j_last && i_last) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        res_addr_d = '0;
                        a_addr_d   = '0;
                        row_base_d = '0;
                        b_addr_d   = '0;
                        b_base_d   = '0;
                    end else begin
                        state_d    = READ;
                        rd_en_d    = 1'b1;
                        res_addr_d = res_addr_q + C_AW'(1);
                        if (j_last) begin
                            row_base_d = row_base_q + A_AW'(N_COLS_A);
                            a_addr_d   = row_base_q + A_AW'(N_COLS_A);
                            b_base_d   = '0;
                            b_addr_d   = '0;
                        end else begin
                            a_addr_d   = row_base_q;
                            b_base_d   = b_base_q + B_AW'(1);
                            b_addr_d   = b_base_q + B_AW'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clear_q <= 1'b0;
            res_valid_q <= 1'b0;
            a_addr_q    <= '0;
            row_base_q  <= '0;
            b_addr_q    <= '0;
            b_base_q    <= '0;
            res_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            mac_en_q    <= mac_en_d;
            mac_clear_q <= mac_clear_d;
            res_valid_q <= res_valid_d;
            a_addr_q    <= a_addr_d;
            row_base_q  <= row_base_d;
            b_addr_q    <= b_addr_d;
            b_base_q    <= b_base_d;
            res_addr_q  <= res_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign a_rd_en   = rd_en_q;
    assign b_rd_en   = rd_en_q;
    assign a_rd_addr = a_addr_q;
    assign b_rd_addr = b_addr_q;
    assign mac_en    = mac_en_q;
    assign mac_clear = mac_clear_q;
    assign res_valid = res_valid_q;
    assign res_addr  = res_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mm_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_mm_sequencer : scoreboard bench for mm_sequencer (8x8x8 and 3x5x2) |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mm_sequencer;

    localparam int NR = 8;
    localparam int KK = 8;
    localparam int NB = 8;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    bit   clk_run = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    logic       rst, start, res_ready;
    logic       busy, done, a_rd_en, b_rd_en, mac_en, mac_clear, res_valid;
    logic [5:0] a_rd_addr, b_rd_addr, res_addr;

    logic       start2, res_ready2;
    logic       busy2, done2, a_rd_en2, b_rd_en2, mac_en2, mac_clear2, res_valid2;
    logic [3:0] a_rd_addr2, b_rd_addr2;
    logic [2:0] res_addr2;

    mm_sequencer #(.N_ROWS_A(NR), .N_COLS_A(KK), .N_COLS_B(NB)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
        .mac_en(mac_en), .mac_clear(mac_clear), .res_valid(res_valid),
        .res_addr(res_addr), .res_ready(res_ready)
    );

    mm_sequencer #(.N_ROWS_A(3), .N_COLS_A(5), .N_COLS_B(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .a_rd_en(a_rd_en2), .a_rd_addr(a_rd_addr2), .b_rd_en(b_rd_en2), .b_rd_addr(b_rd_addr2),
        .mac_en(mac_en2), .mac_clear(mac_clear2), .res_valid(res_valid2),
        .res_addr(res_addr2), .res_ready(res_ready2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int c0 = 0;
    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct { int cyc; int a; int b; } rd_t;
    typedef struct { int cyc; bit clr; } mac_t;
    typedef struct { int cyc; int addr; } wr_t;
    typedef struct { int addr; logic [31:0] val; } c_t;

    rd_t  rq[$];
    mac_t mq[$];
    wr_t  wq[$];
    int   dq[$];
    c_t   cq[$];

    function automatic logic [24:0] outs1();
        return {busy, done, a_rd_en, b_rd_en, mac_en, mac_clear, res_valid,
                a_rd_addr, b_rd_addr, res_addr};
    endfunction

    function automatic logic [17:0] outs2();
        return {busy2, done2, a_rd_en2, b_rd_en2, mac_en2, mac_clear2, res_valid2,
                a_rd_addr2, b_rd_addr2, res_addr2};
    endfunction

    // Scoreboard consumer for the 8x8x8 instance: every strobe must match the next expectation.
    always @(negedge clk) begin
        rd_t  er;
        mac_t em;
        wr_t  ew;
        int   ed;
        int   rel;
        if (mon_en) begin
            rel = cyc - c0;
            checks++;
            if (a_rd_en !== b_rd_en) begin
                errors++;
                $display("FAIL rd_en_pair: a_rd_en=%b b_rd_en=%b at rel %0d, expected equal", a_rd_en, b_rd_en, rel);
            end
            if (a_rd_en === 1'b1) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL read: unexpected read a=%0d b=%0d at rel %0d, expected none", a_rd_addr, b_rd_addr, rel);
                end else begin
                    er = rq.pop_front();
                    if (rel != er.cyc || int'(a_rd_addr) != er.a || int'(b_rd_addr) != er.b) begin
                        errors++;
                        $display("FAIL read: got cyc %0d a %0d b %0d, expected cyc %0d a %0d b %0d",
                                 rel, a_rd_addr, b_rd_addr, er.cyc, er.a, er.b);
                    end
                end
            end
            if (mac_en === 1'b1) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL mac: unexpected mac_en at rel %0d, expected none", rel);
                end else begin
                    em = mq.pop_front();
                    if (rel != em.cyc || mac_clear !== em.clr) begin
                        errors++;
                        $display("FAIL mac: got cyc %0d clear %b, expected cyc %0d clear %b", rel, mac_clear, em.cyc, em.clr);
                    end
                end
            end else begin
                checks++;
                if (mac_clear !== 1'b0) begin
                    errors++;
                    $display("FAIL mac_clear_alone: mac_clear=%b without mac_en at rel %0d, expected 0", mac_clear, rel);
                end
            end
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected handshake addr %0d at rel %0d, expected none", res_addr, rel);
                end else begin
                    ew = wq.pop_front();
                    if (rel != ew.cyc || int'(res_addr) != ew.addr) begin
                        errors++;
                        $display("FAIL write: got cyc %0d addr %0d, expected cyc %0d addr %0d", rel, res_addr, ew.cyc, ew.addr);
                    end
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done: unexpected done at rel %0d, expected none", rel);
                end else begin
                    ed = dq.pop_front();
                    if (rel != ed) begin
                        errors++;
                        $display("FAIL done: got cyc %0d, expected cyc %0d", rel, ed);
                    end
                end
            end
        end
    end

    // Behavioural operand buffers and MAC around the 3x5x2 instance.
    logic [7:0]  amem [15];
    logic [7:0]  bmem [10];
    logic [7:0]  a_q2, b_q2;
    logic [31:0] acc2;
    int          hs2 = 0;

    always @(posedge clk) begin
        if (a_rd_en2) a_q2 <= amem[a_rd_addr2];
        if (b_rd_en2) b_q2 <= bmem[b_rd_addr2];
        if (mac_en2) acc2 <= mac_clear2 ? 32'(a_q2) * 32'(b_q2) : acc2 + 32'(a_q2) * 32'(b_q2);
    end

    always @(negedge clk) begin
        c_t ec;
        if (mon_en && res_valid2 === 1'b1 && res_ready2 === 1'b1) begin
            hs2++;
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL e2e: unexpected result addr %0d val %0d, expected none", res_addr2, acc2);
            end else begin
                ec = cq.pop_front();
                if (int'(res_addr2) != ec.addr || acc2 !== ec.val) begin
                    errors++;
                    $display("FAIL e2e: got addr %0d val %0d, expected addr %0d val %0d", res_addr2, acc2, ec.addr, ec.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int n);
        int guard;
        guard = 0;
        while ((cyc - c0) < n && guard < 5000) begin
            tick();
            guard++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((rq.size() + mq.size() + wq.size() + dq.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic start_run();
        tick();
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    // Expected strobe timeline of one 8x8x8 run, relative to the start-sampling cycle.
    task automatic gen_run(input int base, input int stall_e, input int stall_n, input int cut);
        int s;
        int hv;
        s = base;
        for (int e = 0; e < NR * NB; e++) begin
            for (int k = 0; k < KK; k++) begin
                if (s + 1 + k < cut) rq.push_back('{s + 1 + k, (e / NB) * KK + k, k * NB + (e % NB)});
                if (s + 2 + k < cut) mq.push_back('{s + 2 + k, (k == 0)});
            end
            hv = s + KK + 2 + ((e == stall_e) ? stall_n : 0);
            if (hv < cut) wq.push_back('{hv, e});
            s = hv;
        end
        if (s + 1 < cut) dq.push_back(s + 1);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; res_ready = 1'b1;
        start2 = 1'b0; res_ready2 = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs1() !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h, expected 0", outs1());
        end
        checks++;
        if (outs2() !== '0) begin
            errors++;
            $display("FAIL reset_async_e2e: outputs=%h, expected 0", outs2());
        end
        start = 1'b1;
        clk_run = 1'b1;
        repeat (4) tick();
        checks++;
        if (outs1() !== '0) begin
            errors++;
            $display("FAIL reset_start: outputs=%h with start during reset, expected 0", outs1());
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (outs1() !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h after release, expected 0", outs1());
        end
        mon_en = 1'b1;
    endtask

    task automatic test_addr_seq();
        gen_run(0, -1, 0, BIG);
        start_run();
        wait_rel(641);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL addr_seq_done: done=%b busy=%b at 641, expected 1 1", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL addr_seq_idle: done=%b busy=%b at 642, expected 0 0", done, busy);
        end
        wait_drain(50);
        checks++;
        if ((rq.size() + mq.size() + wq.size() + dq.size()) != 0) begin
            errors++;
            $display("FAIL addr_seq_drain: %0d events pending, expected 0", rq.size() + mq.size() + wq.size() + dq.size());
        end
    endtask

    task automatic test_backpressure();
        gen_run(0, 5, 5, BIG);
        start_run();
        wait_rel(60);
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (res_valid !== 1'b1 || res_addr !== 6'd5 || a_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL stall: res_valid=%b res_addr=%0d a_rd_en=%b, expected 1 5 0", res_valid, res_addr, a_rd_en);
            end
            tick();
        end
        res_ready = 1'b1;
        wait_rel(646);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: done=%b at 646, expected 1", done);
        end
        wait_drain(50);
        checks++;
        if ((rq.size() + mq.size() + wq.size() + dq.size()) != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d events pending, expected 0", rq.size() + mq.size() + wq.size() + dq.size());
        end
    endtask

    task automatic test_start_busy();
        gen_run(0, -1, 0, BIG);
        gen_run(642, -1, 0, BIG);
        start_run();
        wait_rel(100);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_rel(641);
        start = 1'b1;
        wait_rel(643);
        checks++;
        if (a_rd_en !== 1'b1 || a_rd_addr !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: a_rd_en=%b a_rd_addr=%0d busy=%b at 643, expected 1 0 1", a_rd_en, a_rd_addr, busy);
        end
        start = 1'b0;
        wait_drain(800);
        checks++;
        if ((rq.size() + mq.size() + wq.size() + dq.size()) != 0) begin
            errors++;
            $display("FAIL restart_drain: %0d events pending, expected 0", rq.size() + mq.size() + wq.size() + dq.size());
        end
    endtask

    task automatic test_reset_mid_run();
        gen_run(0, -1, 0, 205);
        start_run();
        wait_rel(205);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (outs1() !== '0) begin
            errors++;
            $display("FAIL midrun_async: outputs=%h right after rst, expected 0", outs1());
        end
        checks++;
        if ((rq.size() + mq.size() + wq.size() + dq.size()) != 0) begin
            errors++;
            $display("FAIL midrun_prefix: %0d events pending, expected 0", rq.size() + mq.size() + wq.size() + dq.size());
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: busy=%b after abort, expected 0", busy);
        end
        gen_run(0, -1, 0, BIG);
        start_run();
        wait_drain(700);
        checks++;
        if ((rq.size() + mq.size() + wq.size() + dq.size()) != 0) begin
            errors++;
            $display("FAIL midrun_rerun: %0d events pending, expected 0", rq.size() + mq.size() + wq.size() + dq.size());
        end
    endtask

    task automatic test_end_to_end();
        logic [31:0] sum;
        int n;
        for (int i = 0; i < 15; i++) amem[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) bmem[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                sum = '0;
                for (int k = 0; k < 5; k++) sum = sum + 32'(amem[i * 5 + k]) * 32'(bmem[k * 2 + j]);
                cq.push_back('{i * 2 + j, sum});
            end
        end
        hs2 = 0;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (done2 !== 1'b1) begin
            errors++;
            $display("FAIL e2e_done: done=%b after %0d cycles, expected 1", done2, n);
        end
        repeat (5) tick();
        checks++;
        if (hs2 != 6 || cq.size() != 0) begin
            errors++;
            $display("FAIL e2e_count: handshakes=%0d pending=%0d, expected 6 0", hs2, cq.size());
        end
    endtask

    initial begin
        test_reset();
        test_addr_seq();
        test_backpressure();
        test_start_busy();
        test_reset_mid_run();
        test_end_to_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
